// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: datapath width, bubble encoding,
// reset PC and the fetch FSM state encoding.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef logic [0:0] fetch_state_t;

  localparam fetch_state_t ST_BOOT  = 1'b0;
  localparam fetch_state_t ST_FETCH = 1'b1;

endpackage

// File: rtl/riscv_if_id_reg.sv
// Pipeline register with flush > stall > load > bubble priority.
// A flush or bubble replaces the instruction with NOP and holds the PC fields.
module riscv_if_id_reg
  import riscv_pkg::*;
#(
  parameter int          W   = riscv_pkg::XLEN,
  parameter logic [31:0] NOP = riscv_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         stall_i,
  input  logic         load_i,
  input  logic [31:0]  instr_i,
  input  logic [W-1:0] pc_i,
  output logic [31:0]  instr_o,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_plus4_o,
  output logic         valid_o
);

  logic [31:0]  instr_q;
  logic [W-1:0] pc_q;
  logic [W-1:0] pc_plus4_q;
  logic         valid_q;
  logic         bubble;
  logic         loaded;

  assign bubble = flush_i | (~stall_i & ~load_i);
  assign loaded = ~flush_i & ~stall_i & load_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (bubble) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (loaded) begin
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_i + W'(4);
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/FETCH FSM, redirect handling and IF/ID.
// Define FETCH_PERF_CNT_EN to add fetched/bubble/redirect performance counters.
module riscv_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR,
  parameter int          XLEN      = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_f,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubbles,
  output logic [31:0]     perf_redirects
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d_next;
  logic            fetching;
  logic            load_fire;
  logic            flush_any;

  assign fetching  = (state_q == ST_FETCH);
  assign load_fire = fetching & imem_ready & ~stall_f;
  assign flush_any = flush_d | pc_src_e;

  assign state_d = ST_FETCH;

  // Redirect wins over stall so a resolved branch is never dropped.
  always_comb begin
    pc_d_next = pc_q;
    if (pc_src_e)
      pc_d_next = pc_target_e & ~XLEN'(3);
    else if (load_fire)
      pc_d_next = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC[XLEN-1:0];
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d_next;
    end
  end

  assign imem_req  = fetching;
  assign imem_addr = pc_q;
  assign pc_f      = pc_q;

  riscv_if_id_reg #(
    .W   (XLEN),
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush_any),
    .stall_i    (stall_d),
    .load_i     (load_fire),
    .instr_i    (imem_rdata),
    .pc_i       (pc_q),
    .instr_o    (instr_d),
    .pc_o       (pc_d),
    .pc_plus4_o (pc_plus4_d),
    .valid_o    (valid_d)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, bubbles_q, redirects_q;
  logic        fetched_ev, bubble_ev;

  assign fetched_ev = ~flush_any & ~stall_d & load_fire;
  assign bubble_ev  = flush_any | (~stall_d & ~load_fire);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetched_q   <= '0;
      bubbles_q   <= '0;
      redirects_q <= '0;
    end else begin
      if (fetched_ev) fetched_q   <= fetched_q + 32'd1;
      if (bubble_ev)  bubbles_q   <= bubbles_q + 32'd1;
      if (pc_src_e)   redirects_q <= redirects_q + 32'd1;
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_bubbles   = bubbles_q;
  assign perf_redirects = redirects_q;
`endif

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage: reset, sequential fetch, memory wait,
// stalls, flush, redirects (incl. misaligned and wrap-around) and optional counters.
module tb_riscv_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_redirects;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  riscv_fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .pc_f        (pc_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles),
    .perf_redirects (perf_redirects)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                          input logic [31:0] e_pc4, input logic e_valid);
    chk({tag, ".instr_d"}, instr_d, e_instr);
    chk({tag, ".pc_d"}, pc_d, e_pc);
    chk({tag, ".pc_plus4_d"}, pc_plus4_d, e_pc4);
    chk({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, e_valid});
    $display("step %s: pc_f=%h instr_d=%h pc_d=%h valid_d=%b", tag, pc_f, instr_d, pc_d, valid_d);
  endtask

  initial begin
    reset = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 1'b0; pc_target_e = '0; imem_rdata = 32'h0050_0093; imem_ready = 1'b1;
    tick(); tick();
    chk("rst.pc_f", pc_f, 32'h0);
    chk("rst.imem_req", {31'd0, imem_req}, 32'd0);
    chk_ifid("rst", NOP, 32'h0, 32'h0, 1'b0);

    // BOOT cycle: no request, PC held, bubble
    reset = 1'b1;
    tick();
    chk("boot.pc_f", pc_f, 32'h0);
    chk("boot.imem_req", {31'd0, imem_req}, 32'd1);
    chk("boot.imem_addr", imem_addr, 32'h0);
    chk_ifid("boot", NOP, 32'h0, 32'h0, 1'b0);

    tick();
    chk("f0.pc_f", pc_f, 32'h4);
    chk_ifid("f0", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
    tick();
    chk("f1.pc_f", pc_f, 32'h8);
    chk_ifid("f1", 32'h0050_0093, 32'h4, 32'h8, 1'b1);

    // Memory wait at pc 0x8 for three cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait.pc_f", pc_f, 32'h8);
      chk_ifid("wait", NOP, 32'h4, 32'h8, 1'b0);
    end
    imem_ready = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    chk("wdone.pc_f", pc_f, 32'hC);
    chk_ifid("wdone", 32'h00A0_0113, 32'h8, 32'hC, 1'b1);

    // Stall both stages for two cycles: everything held
    stall_f = 1'b1; stall_d = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall.pc_f", pc_f, 32'hC);
      chk_ifid("stall", 32'h00A0_0113, 32'h8, 32'hC, 1'b1);
    end
    // Flush beats stall_d
    flush_d = 1'b1;
    tick();
    chk("flush.pc_f", pc_f, 32'hC);
    chk_ifid("flush", NOP, 32'h8, 32'hC, 1'b0);
    flush_d = 1'b0;

    // Redirect beats both stalls
    pc_src_e = 1'b1; pc_target_e = 32'h40;
    tick();
    chk("redir.pc_f", pc_f, 32'h40);
    chk_ifid("redir", NOP, 32'h8, 32'hC, 1'b0);
    pc_src_e = 1'b0; stall_f = 1'b0; stall_d = 1'b0; imem_rdata = 32'h0011_8193;
    tick();
    chk("redir2.pc_f", pc_f, 32'h44);
    chk_ifid("redir2", 32'h0011_8193, 32'h40, 32'h44, 1'b1);

    // Misaligned target is forced to word alignment; then wrap to zero
    pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFE;
    tick();
    chk("top.pc_f", pc_f, 32'hFFFF_FFFC);
    chk("top.imem_addr", imem_addr, 32'hFFFF_FFFC);
    chk_ifid("top", NOP, 32'h40, 32'h44, 1'b0);
    pc_src_e = 1'b0;
    tick();
    chk("wrap.pc_f", pc_f, 32'h0);
    chk_ifid("wrap", 32'h0011_8193, 32'hFFFF_FFFC, 32'h0, 1'b1);

    // stall_f alone inserts a bubble and holds PC
    stall_f = 1'b1;
    tick();
    chk("sf.pc_f", pc_f, 32'h0);
    chk_ifid("sf", NOP, 32'hFFFF_FFFC, 32'h0, 1'b0);
    stall_f = 1'b0;
    tick();
    chk("sf2.pc_f", pc_f, 32'h4);
    chk_ifid("sf2", 32'h0011_8193, 32'h0, 32'h4, 1'b1);

    // Redirect during a memory wait discards the outstanding fetch
    imem_ready = 1'b0; pc_src_e = 1'b1; pc_target_e = 32'h103;
    tick();
    chk("rwait.pc_f", pc_f, 32'h100);
    chk_ifid("rwait", NOP, 32'h0, 32'h4, 1'b0);
    pc_src_e = 1'b0;

    // Reset mid-wait
    reset = 1'b0;
    tick();
    chk("mrst.pc_f", pc_f, 32'h0);
    chk("mrst.imem_req", {31'd0, imem_req}, 32'd0);
    chk_ifid("mrst", NOP, 32'h0, 32'h0, 1'b0);

`ifdef FETCH_PERF_CNT_EN
    chk("perf.rst_f", perf_fetched, 32'd0);
    chk("perf.rst_b", perf_bubbles, 32'd0);
    chk("perf.rst_r", perf_redirects, 32'd0);
    imem_ready = 1'b1; reset = 1'b1;
    tick();                                   // BOOT bubble
    for (int i = 0; i < 10; i++) tick();      // 10 fetches
    pc_src_e = 1'b1; pc_target_e = 32'h200;
    tick(); tick();                           // 2 redirect bubbles
    pc_src_e = 1'b0; stall_f = 1'b1;
    tick();                                   // 1 stall bubble
    stall_f = 1'b0;
    chk("perf.fetched", perf_fetched, 32'd10);
    chk("perf.bubbles", perf_bubbles, 32'd4);
    chk("perf.redirects", perf_redirects, 32'd2);
    $display("perf: fetched=%0d bubbles=%0d redirects=%0d", perf_fetched, perf_bubbles, perf_redirects);
    reset = 1'b0;
    tick();
    chk("perf.mrst_f", perf_fetched, 32'd0);
    chk("perf.mrst_b", perf_bubbles, 32'd0);
    chk("perf.mrst_r", perf_redirects, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
